od_input_bank: RTL and testbench

OD_INPUT_BANK -- requirements
Module: od_input_bank

---
 rtl/od_input_bank.sv | 112 +++++++++++
 tb/tb_od_input_bank.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/od_input_bank.sv
// Open-drain input bank: per-channel pad synchronizer, debouncer, edge detect,
// maskable sticky edge-pending flags and a registered pull-low driver.
module od_input_bank #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pin_in,
    input  logic [CHANNELS-1:0] drive_low,
    output logic [CHANNELS-1:0] pad_oe,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    input  logic [CHANNELS-1:0] irq_mask,
    input  logic [CHANNELS-1:0] irq_clear,
    output logic [CHANNELS-1:0] pending,
    output logic                irq
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    // Last count value before acceptance: the increment that would reach
    // DEBOUNCE_CYCLES instead toggles level and clears the counter.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CHANNELS-1:0] r_sync [SYNC_STAGES];
    logic [CHANNELS-1:0] r_pad_oe;
    logic [CHANNELS-1:0] r_level;
    logic [CHANNELS-1:0] r_rise;
    logic [CHANNELS-1:0] r_fall;
    logic [CHANNELS-1:0] r_pending;
    logic [CNT_W-1:0]    r_cnt [CHANNELS];

    logic [CHANNELS-1:0] w_sync;
    logic [CHANNELS-1:0] w_diff;
    logic [CHANNELS-1:0] w_done;
    logic [CHANNELS-1:0] w_edge;

    // Pad synchronizer; idles high to match the external pull-up.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '1;
            end
        end else begin
            r_sync[0] <= pin_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pad_oe <= '0;
        end else begin
            r_pad_oe <= drive_low;
        end
    end

    always_comb begin
        w_diff = w_sync ^ r_level;
        w_done = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            w_done[i] = w_diff[i] && (r_cnt[i] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                r_cnt[i] <= '0;
            end
            r_level <= '1;
            r_rise  <= '0;
            r_fall  <= '0;
        end else begin
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                if (!w_diff[i] || w_done[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
            r_level <= r_level ^ w_done;
            r_rise  <= w_done & w_sync;
            r_fall  <= w_done & ~w_sync;
        end
    end

    assign w_edge = r_rise | r_fall;

    // Set has priority over write-1-to-clear on the same channel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~irq_clear) | (w_edge & irq_mask);
        end
    end

    assign pad_oe  = r_pad_oe;
    assign level   = r_level;
    assign rise    = r_rise;
    assign fall    = r_fall;
    assign pending = r_pending;
    assign irq     = |r_pending;

endmodule

// File: tb/tb_od_input_bank.sv
// Scoreboard bench for od_input_bank: expected edge pulses are queued with the
// cycle they must appear in and matched by a negedge monitor.
module tb_od_input_bank;

    localparam int CH  = 4;
    localparam int SS  = 2;
    localparam int DB  = 16;
    localparam int LAT = SS + DB - 1;

    typedef struct {
        int         at;
        logic [3:0] r;
        logic [3:0] f;
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] pin_drv = '1;
    logic          loopback = 1'b0;
    logic [CH-1:0] pin_in;
    logic [CH-1:0] drive_low = '0;
    logic [CH-1:0] irq_mask = '0;
    logic [CH-1:0] irq_clear = '0;
    logic [CH-1:0] pad_oe;
    logic [CH-1:0] level;
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [CH-1:0] pending;
    logic          irq;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t exp_q[$];

    assign pin_in = loopback ? ~pad_oe : pin_drv;

    od_input_bank #(
        .CHANNELS(CH),
        .SYNC_STAGES(SS),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pin_in(pin_in),
        .drive_low(drive_low),
        .pad_oe(pad_oe),
        .level(level),
        .rise(rise),
        .fall(fall),
        .irq_mask(irq_mask),
        .irq_clear(irq_clear),
        .pending(pending),
        .irq(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            checks++;
            failures++;
            $display("FAIL edge_missed due_cycle=%0d want rise=%b fall=%b", exp_q[0].at, exp_q[0].r, exp_q[0].f);
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
            checks++;
            if (rise !== exp_q[0].r || fall !== exp_q[0].f) begin
                failures++;
                $display("FAIL edge_pulse cycle=%0d got rise=%b fall=%b want rise=%b fall=%b",
                         cyc, rise, fall, exp_q[0].r, exp_q[0].f);
            end
            void'(exp_q.pop_front());
        end else if ((rise | fall) !== 4'h0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_edge cycle=%0d got rise=%b fall=%b want none", cyc, rise, fall);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_edge(input int at, input logic [3:0] r, input logic [3:0] f);
        ev_t e;
        e.at = at;
        e.r  = r;
        e.f  = f;
        exp_q.push_back(e);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive_low = 4'hF;
        pin_drv = 4'h0;
        tick(3);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL reset_level got=%h want=f", level); end
        checks++; if (pad_oe !== 4'h0) begin failures++; $display("FAIL reset_pad_oe got=%h want=0", pad_oe); end
        checks++; if (rise !== 4'h0 || fall !== 4'h0) begin failures++; $display("FAIL reset_edges got rise=%h fall=%h want 0", rise, fall); end
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL reset_pending got=%h want=0", pending); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
        drive_low = 4'h0;
        pin_drv = 4'hF;
        tick(2);
        reset = 1'b0;
        tick(2);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL post_reset_level got=%h want=f", level); end
    endtask

    task automatic test_fall;
        int c;
        irq_mask = 4'hF;
        c = cyc;
        pin_drv[0] = 1'b0;
        expect_edge(c + 1 + LAT, 4'h0, 4'h1);
        tick(LAT);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL fall_early_level got=%h want=f", level); end
        tick(1);
        checks++; if (level !== 4'hE) begin failures++; $display("FAIL fall_level got=%h want=e", level); end
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL fall_pending_latency got=%h want=0", pending); end
        tick(1);
        checks++; if (pending !== 4'h1) begin failures++; $display("FAIL fall_pending got=%h want=1", pending); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL fall_irq got=%b want=1", irq); end
        irq_mask = 4'h0;
        tick(1);
        checks++; if (pending !== 4'h1) begin failures++; $display("FAIL mask_change_pending got=%h want=1", pending); end
        irq_mask = 4'hF;
        irq_clear = 4'h1;
        tick(1);
        irq_clear = 4'h0;
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL clear_pending got=%h want=0", pending); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL clear_irq got=%b want=0", irq); end
    endtask

    task automatic test_rise;
        int c;
        c = cyc;
        pin_drv[0] = 1'b1;
        expect_edge(c + 1 + LAT, 4'h1, 4'h0);
        tick(LAT + 1);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL rise_level got=%h want=f", level); end
        tick(1);
        checks++; if (pending !== 4'h1) begin failures++; $display("FAIL rise_pending got=%h want=1", pending); end
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
    endtask

    task automatic test_glitch;
        int c;
        pin_drv[1] = 1'b0;
        tick(DB - 1);
        pin_drv[1] = 1'b1;
        tick(30);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL glitch_level got=%h want=f", level); end
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL glitch_pending got=%h want=0", pending); end
        // A pulse of exactly DB cycles is long enough to be accepted both ways.
        c = cyc;
        pin_drv[1] = 1'b0;
        expect_edge(c + 1 + LAT, 4'h0, 4'h2);
        tick(DB);
        pin_drv[1] = 1'b1;
        expect_edge(c + 1 + LAT + DB, 4'h2, 4'h0);
        tick(LAT + 4);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL min_pulse_level got=%h want=f", level); end
        checks++; if (pending !== 4'h2) begin failures++; $display("FAIL min_pulse_pending got=%h want=2", pending); end
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
    endtask

    task automatic test_clear_set;
        int c;
        irq_mask = 4'hF;
        c = cyc;
        pin_drv[0] = 1'b0;
        expect_edge(c + 1 + LAT, 4'h0, 4'h1);
        tick(LAT + 2);
        checks++; if (pending !== 4'h1) begin failures++; $display("FAIL cs_pre_pending got=%h want=1", pending); end
        c = cyc;
        pin_drv[2] = 1'b0;
        expect_edge(c + 1 + LAT, 4'h0, 4'h4);
        tick(LAT + 1);
        irq_clear = 4'h5;
        tick(1);
        irq_clear = 4'h0;
        checks++; if (pending !== 4'h4) begin failures++; $display("FAIL set_wins_pending got=%h want=4", pending); end
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL set_wins_irq got=%b want=1", irq); end
        c = cyc;
        pin_drv = 4'hF;
        expect_edge(c + 1 + LAT, 4'h5, 4'h0);
        tick(LAT + 2);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL cs_restore_level got=%h want=f", level); end
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL cs_clear_all got=%h want=0", pending); end
    endtask

    task automatic test_mask_all;
        int c;
        irq_mask = 4'h0;
        c = cyc;
        pin_drv = 4'h0;
        expect_edge(c + 1 + LAT, 4'h0, 4'hF);
        tick(LAT + 1);
        checks++; if (level !== 4'h0) begin failures++; $display("FAIL masked_level got=%h want=0", level); end
        tick(1);
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL masked_pending got=%h want=0", pending); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq got=%b want=0", irq); end
        c = cyc;
        pin_drv = 4'hF;
        expect_edge(c + 1 + LAT, 4'hF, 4'h0);
        tick(LAT + 2);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL masked_rise_level got=%h want=f", level); end
        checks++; if (pending !== 4'h0) begin failures++; $display("FAIL masked_rise_pending got=%h want=0", pending); end
    endtask

    task automatic test_loopback;
        int c;
        irq_mask = 4'hF;
        loopback = 1'b1;
        c = cyc;
        drive_low = 4'h8;
        checks++; if (pad_oe !== 4'h0) begin failures++; $display("FAIL pad_oe_comb got=%h want=0", pad_oe); end
        expect_edge(c + 2 + LAT, 4'h0, 4'h8);
        tick(1);
        checks++; if (pad_oe !== 4'h8) begin failures++; $display("FAIL pad_oe_latency got=%h want=8", pad_oe); end
        tick(LAT + 1);
        checks++; if (level !== 4'h7) begin failures++; $display("FAIL loop_level got=%h want=7", level); end
        tick(1);
        checks++; if (pending !== 4'h8) begin failures++; $display("FAIL loop_pending got=%h want=8", pending); end
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
        c = cyc;
        drive_low = 4'h0;
        expect_edge(c + 2 + LAT, 4'h8, 4'h0);
        tick(LAT + 2);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL loop_release_level got=%h want=f", level); end
        tick(1);
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
        loopback = 1'b0;
    endtask

    task automatic test_reset_mid;
        int c;
        irq_mask = 4'hF;
        pin_drv[0] = 1'b0;
        tick(12);
        reset = 1'b1;
        tick(3);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL mid_reset_level got=%h want=f", level); end
        checks++; if (pending !== 4'h0 || irq !== 1'b0) begin failures++; $display("FAIL mid_reset_pending got=%h irq=%b want 0", pending, irq); end
        reset = 1'b0;
        c = cyc;
        expect_edge(c + 1 + LAT, 4'h0, 4'h1);
        tick(LAT);
        checks++; if (level !== 4'hF) begin failures++; $display("FAIL post_reset_early_level got=%h want=f", level); end
        tick(1);
        checks++; if (level !== 4'hE) begin failures++; $display("FAIL post_reset_level got=%h want=e", level); end
        tick(1);
        checks++; if (pending !== 4'h1) begin failures++; $display("FAIL post_reset_pending got=%h want=1", pending); end
        c = cyc;
        pin_drv = 4'hF;
        expect_edge(c + 1 + LAT, 4'h1, 4'h0);
        tick(LAT + 2);
        irq_clear = 4'hF;
        tick(1);
        irq_clear = 4'h0;
    endtask

    initial begin
        test_reset();
        test_fall();
        test_rise();
        test_glitch();
        test_clear_set();
        test_mask_all();
        test_loopback();
        test_reset_mid();
        tick(5);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d outstanding want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL timeout got=cycle %0d want=finish", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
